// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    // Quotient reported for a zero divisor (DIV and DIVU alike).
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring step: shift a dividend bit into the partial remainder,
// trial-subtract the divisor and keep the difference only if it is non-negative.
module div_restore_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] rem_shifted;
    logic [WIDTH:0] trial;

    // rem < divisor, so |trial| < 2^WIDTH and bit WIDTH is a reliable sign.
    always_comb begin
        rem_shifted = {rem, dvd_msb};
        trial       = rem_shifted - {1'b0, divisor};
        q_bit       = ~trial[WIDTH];
        rem_next    = q_bit ? trial[WIDTH-1:0] : rem_shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider.sv
// Iterative DIV/DIVU unit: one quotient bit per clock, level begin/end handshake,
// quotient to LO and remainder to HI.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_begin,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_op1,
    input  logic [WIDTH-1:0] div_op2,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_busy,
    output logic             div_end
);

    div_state_t       state_reg, state_next;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;
    logic [WIDTH-1:0] rem_step;
    logic             q_bit;
    logic [WIDTH-1:0] quot_raw;
    logic             last_step;

    assign op1_abs   = (div_signed && div_op1[WIDTH-1]) ? -div_op1 : div_op1;
    assign op2_abs   = (div_signed && div_op2[WIDTH-1]) ? -div_op2 : div_op2;
    // Quotient bits enter at the LSB as the dividend drains out of the MSB.
    assign quot_raw  = {dvd_reg[WIDTH-2:0], q_bit};
    assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

    div_restore_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem_reg),
        .dvd_msb  (dvd_reg[WIDTH-1]),
        .divisor  (dvs_reg),
        .rem_next (rem_step),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (div_begin) begin
                    state_next = (div_op2 == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (!div_begin) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!div_begin) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_reg       <= '0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (div_begin) begin
                        if (div_op2 == '0) begin
                            quotient_reg  <= WIDTH'(DIV0_QUOT);
                            remainder_reg <= div_op1;
                        end else begin
                            rem_reg   <= '0;
                            dvd_reg   <= op1_abs;
                            dvs_reg   <= op2_abs;
                            q_neg_reg <= div_signed & (div_op1[WIDTH-1] ^ div_op2[WIDTH-1]);
                            r_neg_reg <= div_signed & div_op1[WIDTH-1];
                            cnt_reg   <= '0;
                        end
                    end
                end
                CALC: begin
                    // A dropped request abandons the operation; outputs keep old values.
                    if (div_begin) begin
                        rem_reg <= rem_step;
                        dvd_reg <= quot_raw;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (last_step) begin
                            quotient_reg  <= q_neg_reg ? -quot_raw : quot_raw;
                            remainder_reg <= r_neg_reg ? -rem_step : rem_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign div_busy  = (state_reg == CALC);
    assign div_end   = (state_reg == DONE);

endmodule
